// File: rtl/squeeze_serializer_if.sv
// Handshake bundle for squeeze_serializer.
//   slave  : the serializer side (captures blocks, emits words)
//   master : the surrounding logic (permute stage upstream, word consumer downstream)
// Signals:
//   block_valid_i / block_ready_o : block handshake with the permute stage
//   rate_i, operation_mode_i, output_size_i : block payload
//   data_o, data_valid_o, data_ready_i, data_last_o : output word stream
//   data_keep_o : byte strobes, present only when OUTPUT_BYTE_KEEP_EN is defined
interface squeeze_serializer_if #(
   parameter int WORD_WIDTH = 64,
   parameter int RATE_WIDTH = 1344,
   parameter int SIZE_WIDTH = 32
);
   logic                    block_valid_i;
   logic                    block_ready_o;
   logic [RATE_WIDTH-1:0]   rate_i;
   logic [1:0]              operation_mode_i;
   logic [SIZE_WIDTH-1:0]   output_size_i;
   logic [WORD_WIDTH-1:0]   data_o;
   logic                    data_valid_o;
   logic                    data_ready_i;
   logic                    data_last_o;
`ifdef OUTPUT_BYTE_KEEP_EN
   logic [WORD_WIDTH/8-1:0] data_keep_o;
`endif

   modport slave (
      input  block_valid_i, rate_i, operation_mode_i, output_size_i, data_ready_i,
`ifdef OUTPUT_BYTE_KEEP_EN
      output data_keep_o,
`endif
      output block_ready_o, data_o, data_valid_o, data_last_o
   );

   modport master (
      output block_valid_i, rate_i, operation_mode_i, output_size_i, data_ready_i,
`ifdef OUTPUT_BYTE_KEEP_EN
      input  data_keep_o,
`endif
      input  block_ready_o, data_o, data_valid_o, data_last_o
   );
endinterface

// File: rtl/squeeze_serializer.sv
// squeeze_serializer: takes one squeezed rate block per handshake and streams
// it out as WORD_WIDTH-bit words, most significant word first. The final
// word of the digest is zero-masked below the remaining bit count and flagged
// with data_last_o. A block never yields more than its rate in words; when a
// block runs out before the digest does, the stage drops to IDLE for one
// cycle to take the next block.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : squeeze_serializer_if.slave (block handshake + word stream)
//
// Mode encoding: 2'b01 = SHAKE128 (21 words/block), 2'b10 = SHAKE256
// (17 words/block); any other code is invalid and the block is dropped.
//
// Optional feature macro: OUTPUT_BYTE_KEEP_EN adds data_keep_o; keep bit
// NB-1 (MSB) covers the most significant byte of data_o.
//
// state | meaning
// IDLE  | ready for a block, no word on the bus
// EMIT  | presenting a word of the captured block
module squeeze_serializer #(
   parameter int WORD_WIDTH = 64,
   parameter int RATE_WIDTH = 1344,
   parameter int SIZE_WIDTH = 32
) (
   input logic                   clk,
   input logic                   rst,
   squeeze_serializer_if.slave   bus
);

   localparam int NB = WORD_WIDTH / 8;
   localparam logic [1:0] SHAKE128_MODE_VEC = 2'b01;
   localparam logic [1:0] SHAKE256_MODE_VEC = 2'b10;
   localparam logic [SIZE_WIDTH-1:0] W_BITS = SIZE_WIDTH'(WORD_WIDTH);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  r_state;
   logic [RATE_WIDTH-1:0]   r_sr;
   logic [SIZE_WIDTH-1:0]   r_bits_left;
   logic [4:0]              r_word_cnt;
   logic [4:0]              r_words_in_block;
   logic                    r_block_ready;
   logic                    r_data_valid;
   logic                    r_data_last;
   logic [WORD_WIDTH-1:0]   r_data;
`ifdef OUTPUT_BYTE_KEEP_EN
   logic [NB-1:0]           r_data_keep;
`endif

   logic [RATE_WIDTH-1:0]   w_sr_shift;
   logic [SIZE_WIDTH-1:0]   w_bits_after;
   logic                    w_mode_ok;
   logic [4:0]              w_wib_new;

   // Keep only the upper 'bits' bits of a word; a full word passes through.
   function automatic logic [WORD_WIDTH-1:0] mask_word(
      input logic [WORD_WIDTH-1:0] word,
      input logic [SIZE_WIDTH-1:0] bits
   );
      if (bits >= W_BITS)
         return word;
      return word & ~({WORD_WIDTH{1'b1}} >> bits);
   endfunction

`ifdef OUTPUT_BYTE_KEEP_EN
   // ceil(bits/8) leading ones for a partial word.
   function automatic logic [NB-1:0] keep_for(input logic [SIZE_WIDTH-1:0] bits);
      logic [SIZE_WIDTH-1:0] n;
      if (bits >= W_BITS)
         return '1;
      n = (bits + SIZE_WIDTH'(7)) >> 3;
      return ~({NB{1'b1}} >> n);
   endfunction
`endif

   always_comb begin
      w_sr_shift   = {r_sr[RATE_WIDTH-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
      w_bits_after = (r_bits_left > W_BITS) ? (r_bits_left - W_BITS) : '0;
      w_mode_ok    = 1'b1;
      w_wib_new    = 5'd21;
      case (bus.operation_mode_i)
         SHAKE128_MODE_VEC: w_wib_new = 5'd21;
         SHAKE256_MODE_VEC: w_wib_new = 5'd17;
         default:           w_mode_ok = 1'b0;
      endcase
   end

   // Outputs are registered, so each transition preloads the word that will
   // be presented in the next cycle (masked against the bits left then).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state          <= IDLE;
         r_sr             <= '0;
         r_bits_left      <= '0;
         r_word_cnt       <= '0;
         r_words_in_block <= '0;
         r_block_ready    <= 1'b1;
         r_data_valid     <= 1'b0;
         r_data_last      <= 1'b0;
         r_data           <= '0;
`ifdef OUTPUT_BYTE_KEEP_EN
         r_data_keep      <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               // Invalid mode or empty request: handshake completes, block dropped.
               if (bus.block_valid_i && w_mode_ok && (bus.output_size_i != '0)) begin
                  r_sr             <= bus.rate_i;
                  r_bits_left      <= bus.output_size_i;
                  r_words_in_block <= w_wib_new;
                  r_word_cnt       <= '0;
                  r_data           <= mask_word(bus.rate_i[RATE_WIDTH-1 -: WORD_WIDTH],
                                                bus.output_size_i);
                  r_data_last      <= (bus.output_size_i <= W_BITS);
`ifdef OUTPUT_BYTE_KEEP_EN
                  r_data_keep      <= keep_for(bus.output_size_i);
`endif
                  r_data_valid     <= 1'b1;
                  r_block_ready    <= 1'b0;
                  r_state          <= EMIT;
               end
            end
            EMIT: begin
               if (bus.data_ready_i) begin
                  r_sr        <= w_sr_shift;
                  r_bits_left <= w_bits_after;
                  r_word_cnt  <= r_word_cnt + 5'd1;
                  if (r_data_last || (r_word_cnt == r_words_in_block - 5'd1)) begin
                     r_state       <= IDLE;
                     r_data_valid  <= 1'b0;
                     r_block_ready <= 1'b1;
                     r_data_last   <= 1'b0;
                     r_data        <= '0;
`ifdef OUTPUT_BYTE_KEEP_EN
                     r_data_keep   <= '0;
`endif
                  end else begin
                     r_data      <= mask_word(w_sr_shift[RATE_WIDTH-1 -: WORD_WIDTH],
                                              w_bits_after);
                     r_data_last <= (w_bits_after <= W_BITS);
`ifdef OUTPUT_BYTE_KEEP_EN
                     r_data_keep <= keep_for(w_bits_after);
`endif
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.block_ready_o = r_block_ready;
   assign bus.data_valid_o  = r_data_valid;
   assign bus.data_last_o   = r_data_last;
   assign bus.data_o        = r_data;
`ifdef OUTPUT_BYTE_KEEP_EN
   assign bus.data_keep_o   = r_data_keep;
`endif

endmodule

// File: tb/tb_squeeze_serializer.sv
module tb_squeeze_serializer;

   localparam int W    = 64;
   localparam int RATE = 1344;
   localparam int SW   = 32;
   localparam logic [1:0] M128 = 2'b01;
   localparam logic [1:0] M256 = 2'b10;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      logic [7:0]   keep;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   squeeze_serializer_if #(.WORD_WIDTH(W), .RATE_WIDTH(RATE), .SIZE_WIDTH(SW)) bus ();

   squeeze_serializer #(.WORD_WIDTH(W), .RATE_WIDTH(RATE), .SIZE_WIDTH(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t         sb_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           hs_cnt   = 0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_data;
   logic         stall_last;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (stall_prev && bus.data_valid_o) begin
         chk("stall_data", bus.data_o, stall_data);
         chk("stall_last", W'(bus.data_last_o), W'(stall_last));
      end
      stall_prev = bus.data_valid_o && !bus.data_ready_i;
      stall_data = bus.data_o;
      stall_last = bus.data_last_o;
      if (bus.data_valid_o && bus.data_ready_i && rst) begin
         hs_cnt++;
         if (sb_q.size() == 0) begin
            chk("unexpected_word", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("data", bus.data_o, e.data);
            chk("last", W'(bus.data_last_o), W'(e.last));
`ifdef OUTPUT_BYTE_KEEP_EN
            chk("keep", W'(bus.data_keep_o), W'(e.keep));
`endif
         end
      end
   end

   task automatic push_expected(input logic [RATE-1:0] rate, input logic [1:0] mode,
                                input logic [SW-1:0] size);
      int wib;
      logic [SW-1:0] bl;
      exp_t e;
      wib = (mode == M128) ? 21 : (mode == M256) ? 17 : 0;
      bl  = size;
      for (int k = 0; k < wib && bl != 0; k++) begin
         e.data = rate[RATE-1-W*k -: W];
         if (bl < 64) e.data = e.data & ~(64'hFFFF_FFFF_FFFF_FFFF >> bl);
         e.last = (bl <= 64);
         e.keep = (bl >= 64) ? 8'hFF : ~(8'hFF >> ((bl + 7) / 8));
         bl = (bl > 64) ? bl - 64 : 0;
         sb_q.push_back(e);
      end
   endtask

   task automatic send_block(input logic [RATE-1:0] rate, input logic [1:0] mode,
                             input logic [SW-1:0] size, input logic expect_words);
      int n = 0;
      while (!bus.block_ready_o && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("block_ready_timeout", 0, 1);
      bus.rate_i           = rate;
      bus.operation_mode_i = mode;
      bus.output_size_i    = size;
      bus.block_valid_i    = 1'b1;
      push_expected(rate, mode, size);
      @(posedge clk); #1;
      bus.block_valid_i = 1'b0;
      chk("first_valid_latency", W'(bus.data_valid_o), W'(expect_words));
      chk("ready_after_capture", W'(bus.block_ready_o), W'(!expect_words));
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || bus.data_valid_o) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= budget) chk("drain_timeout", 0, 1);
      chk("idle_ready", W'(bus.block_ready_o), 1);
      chk("idle_valid", W'(bus.data_valid_o), 0);
   endtask

   task automatic wait_hs(input int target);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (hs_cnt < target && n < 200);
      if (n >= 200) chk("hs_timeout", 0, 1);
   endtask

   logic [RATE-1:0] r_ramp, r_ones, r_rand;

   initial begin
      for (int k = 0; k < 21; k++) begin
         r_ramp[RATE-1-W*k -: W] = 64'h0101_0101_0101_0101 * 64'(k);
         r_rand[RATE-1-W*k -: W] = {$urandom, $urandom};
      end
      r_ones = '1;
      bus.block_valid_i    = 1'b0;
      bus.rate_i           = '0;
      bus.operation_mode_i = 2'b00;
      bus.output_size_i    = '0;
      bus.data_ready_i     = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", W'(bus.block_ready_o), 1);
      chk("rst_valid", W'(bus.data_valid_o), 0);
      chk("rst_last",  W'(bus.data_last_o), 0);
      chk("rst_data",  bus.data_o, 0);
`ifdef OUTPUT_BYTE_KEEP_EN
      chk("rst_keep",  W'(bus.data_keep_o), 0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;

      // Full SHAKE128 block, last on word 20
      send_block(r_ramp, M128, 32'd1344, 1'b1);
      wait_drain(200);

      // SHAKE256, 4 words
      send_block(r_rand, M256, 32'd256, 1'b1);
      wait_drain(200);

      // Partial final word
      send_block(r_ones, M128, 32'd100, 1'b1);
      wait_drain(200);

      // Multi-block: 21 words without last, bubble, then 11 words
      send_block(r_rand, M128, 32'd2000, 1'b1);
      wait_drain(200);
      send_block(r_ramp, M128, 32'd656, 1'b1);
      wait_drain(200);

      // SHAKE256 block limit: size larger than rate, 17 words no last
      send_block(r_ramp, M256, 32'd5000, 1'b1);
      wait_drain(200);

      // Backpressure on word 5
      hs_cnt = 0;
      send_block(r_ramp, M128, 32'd1344, 1'b1);
      wait_hs(5);
      bus.data_ready_i = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      bus.data_ready_i = 1'b1;
      wait_drain(200);
      chk("bp_word_count", W'(hs_cnt), 21);

      // Reset during word 7
      hs_cnt = 0;
      send_block(r_rand, M128, 32'd1344, 1'b1);
      wait_hs(7);
      bus.data_ready_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", W'(bus.data_valid_o), 0);
      chk("midrst_ready", W'(bus.block_ready_o), 1);
      chk("midrst_data",  bus.data_o, 0);
      sb_q.delete();
      rst = 1'b1;
      bus.data_ready_i = 1'b1;
      @(posedge clk); #1;
      chk("midrst_still_idle", W'(bus.data_valid_o), 0);
      send_block(r_ramp, M128, 32'd300, 1'b1);
      wait_drain(200);

      // Invalid mode and zero size: accepted, nothing emitted
      send_block(r_ramp, 2'b00, 32'd1344, 1'b0);
      send_block(r_ramp, 2'b11, 32'd64, 1'b0);
      send_block(r_ramp, M128, 32'd0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.data_valid_o) chk("invalid_no_valid", W'(bus.data_valid_o), 0);
      end
      chk("invalid_q_empty", W'(sb_q.size()), 0);

      // A valid block afterwards still works
      send_block(r_ones, M256, 32'd64, 1'b1);
      wait_drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
